// File: rtl/gowin_pll_ctrl_pkg.sv
// Shared types and constants for the Gowin PLL power-up / recovery sequencer.
package gowin_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    EN_CLK    = 3'd3,
    RUN       = 3'd4,
    ERROR     = 3'd5
  } pll_state_t;

  typedef logic [5:0] icpsel_t;
  typedef logic [2:0] lpfres_t;
  typedef logic [1:0] lpfcap_t;

  localparam icpsel_t DEFAULT_ICPSEL = 6'd16;
  localparam lpfres_t DEFAULT_LPFRES = 3'd2;
  localparam lpfcap_t DEFAULT_LPFCAP = 2'd0;

  // Largest of four counts; sizes the shared sequencing counter.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // 8-bit increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/gowin_pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module gowin_pll_lock_sync
  import gowin_pll_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Shift the raw lock through two stages; both clear to "not locked".
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/gowin_pll_ctrl.sv
// PLL sequencer: reset pulse, lock wait with retry budget, lock qualification,
// staged clock enables, system reset release, lock-loss recovery and
// runtime loop-filter reconfiguration.
module gowin_pll_ctrl #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int EN_GAP_CYCLES = 8,
  parameter int MAX_RETRIES   = 3,
  parameter gowin_pll_ctrl_pkg::icpsel_t DEFAULT_ICPSEL = gowin_pll_ctrl_pkg::DEFAULT_ICPSEL,
  parameter gowin_pll_ctrl_pkg::lpfres_t DEFAULT_LPFRES = gowin_pll_ctrl_pkg::DEFAULT_LPFRES,
  parameter gowin_pll_ctrl_pkg::lpfcap_t DEFAULT_LPFCAP = gowin_pll_ctrl_pkg::DEFAULT_LPFCAP
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       lock_i,
  output logic       pll_reset_o,
  output logic       enclk0_o,
  output logic       enclk2_o,
  output logic [5:0] icpsel_o,
  output logic [2:0] lpfres_o,
  output logic [1:0] lpfcap_o,
  output logic       sys_rst_o,
  output logic       locked_o,
  output logic       error_o,
  output logic [7:0] lost_cnt_o,
  input  logic       cfg_valid_i,
  input  logic [5:0] cfg_icpsel_i,
  input  logic [2:0] cfg_lpfres_i,
  input  logic [1:0] cfg_lpfcap_i,
  output logic       cfg_ready_o
);
  import gowin_pll_ctrl_pkg::*;

  localparam int CNT_MAX = max_of4(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, EN_GAP_CYCLES);
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int RW      = $clog2(MAX_RETRIES) + 1;

  // Terminal counts: the counter starts at 0 on state entry.
  localparam logic [CW-1:0] RST_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST   = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(EN_GAP_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(2 * EN_GAP_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);

  logic          lock_s;
  logic          accept_s;
  logic          loss_s;
  pll_state_t    state_r;
  logic [CW-1:0] cnt_r;
  logic [RW-1:0] retries_r;
  logic          pll_reset_r;
  logic          enclk0_r;
  logic          enclk2_r;
  logic          sys_rst_r;
  logic          locked_r;
  logic          error_r;
  logic          cfg_ready_r;
  icpsel_t       icpsel_r;
  lpfres_t       lpfres_r;
  lpfcap_t       lpfcap_r;
  logic [7:0]    lost_cnt_r;

  gowin_pll_lock_sync u_lock_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (lock_i),
    .q   (lock_s)
  );

  // cfg_ready is only high in RUN/ERROR, so an accept can only happen there.
  assign accept_s = cfg_valid_i && cfg_ready_r;
  // Losing lock once the enables may be up forces a full restart.
  assign loss_s   = !lock_s && ((state_r == EN_CLK) || (state_r == RUN));

  // Sequencer FSM with all outputs registered; restart requests take priority over normal stepping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= RESET_PLL;
      cnt_r       <= '0;
      retries_r   <= '0;
      pll_reset_r <= 1'b1;
      enclk0_r    <= 1'b0;
      enclk2_r    <= 1'b0;
      sys_rst_r   <= 1'b1;
      locked_r    <= 1'b0;
      error_r     <= 1'b0;
      cfg_ready_r <= 1'b0;
      lost_cnt_r  <= 8'd0;
      icpsel_r    <= DEFAULT_ICPSEL;
      lpfres_r    <= DEFAULT_LPFRES;
      lpfcap_r    <= DEFAULT_LPFCAP;
    end else if (accept_s || loss_s) begin
      // Common restart: PLL back into reset, downstream logic held in reset.
      state_r     <= RESET_PLL;
      cnt_r       <= '0;
      pll_reset_r <= 1'b1;
      enclk0_r    <= 1'b0;
      enclk2_r    <= 1'b0;
      sys_rst_r   <= 1'b1;
      locked_r    <= 1'b0;
      cfg_ready_r <= 1'b0;
      if (accept_s) begin
        // New loop settings land on the same edge pll_reset is (re)asserted.
        icpsel_r  <= cfg_icpsel_i;
        lpfres_r  <= cfg_lpfres_i;
        lpfcap_r  <= cfg_lpfcap_i;
        retries_r <= '0;
        error_r   <= 1'b0;
      end
      if (loss_s) begin
        lost_cnt_r <= sat_inc8(lost_cnt_r);
      end
    end else begin
      case (state_r)
        RESET_PLL: begin
          if (cnt_r == RST_LAST) begin
            state_r     <= WAIT_LOCK;
            cnt_r       <= '0;
            pll_reset_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_r <= STABLE;
            cnt_r   <= '0;
          end else if (cnt_r == TO_LAST) begin
            cnt_r       <= '0;
            pll_reset_r <= 1'b1;
            retries_r   <= retries_r + RW'(1);
            if (retries_r == RETRY_LAST) begin
              state_r     <= ERROR;
              error_r     <= 1'b1;
              cfg_ready_r <= 1'b1;
            end else begin
              state_r <= RESET_PLL;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            // Glitch: restart the lock wait with a fresh timeout, keep retries.
            state_r <= WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r == STB_LAST) begin
            state_r  <= EN_CLK;
            cnt_r    <= '0;
            enclk0_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        EN_CLK: begin
          // Lock is known good here (loss handled above); one counter spans both gaps.
          if (cnt_r == GAP_LAST) begin
            enclk2_r <= 1'b1;
          end
          if (cnt_r == RUN_LAST) begin
            state_r     <= RUN;
            cnt_r       <= '0;
            sys_rst_r   <= 1'b0;
            locked_r    <= 1'b1;
            cfg_ready_r <= 1'b1;
            retries_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RUN: begin
          cnt_r <= '0;
        end
        ERROR: begin
          cnt_r <= '0;
        end
        default: begin
          state_r     <= RESET_PLL;
          cnt_r       <= '0;
          pll_reset_r <= 1'b1;
          enclk0_r    <= 1'b0;
          enclk2_r    <= 1'b0;
          sys_rst_r   <= 1'b1;
          locked_r    <= 1'b0;
          cfg_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset_o = pll_reset_r;
  assign enclk0_o    = enclk0_r;
  assign enclk2_o    = enclk2_r;
  assign icpsel_o    = icpsel_r;
  assign lpfres_o    = lpfres_r;
  assign lpfcap_o    = lpfcap_r;
  assign sys_rst_o   = sys_rst_r;
  assign locked_o    = locked_r;
  assign error_o     = error_r;
  assign lost_cnt_o  = lost_cnt_r;
  assign cfg_ready_o = cfg_ready_r;

endmodule

// File: tb/tb_gowin_pll_ctrl.sv
// Directed + randomized bench for gowin_pll_ctrl. Expected timing comes from
// the cycle formulas of the sequencer (sync + qualification + enable gaps).
module tb_gowin_pll_ctrl;

  localparam int RC    = 4;
  localparam int LT    = 20;
  localparam int SC    = 8;
  localparam int GAP   = 2;
  localparam int MR    = 2;
  // Cycles from lock_i rising to each event.
  localparam int T_E0  = 3 + SC;
  localparam int T_E2  = T_E0 + GAP;
  localparam int T_RUN = T_E2 + GAP;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       cfg_valid;
  logic [5:0] cfg_icpsel;
  logic [2:0] cfg_lpfres;
  logic [1:0] cfg_lpfcap;
  logic       pll_reset, enclk0, enclk2, sys_rst, locked, error, cfg_ready;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap;
  logic [7:0] lost_cnt;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference state: loop settings currently in force and lock-loss count.
  logic [10:0] exp_loop;
  logic [7:0]  exp_lost;

  gowin_pll_ctrl #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .EN_GAP_CYCLES(GAP),
    .MAX_RETRIES  (MR)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .lock_i       (lock),
    .pll_reset_o  (pll_reset),
    .enclk0_o     (enclk0),
    .enclk2_o     (enclk2),
    .icpsel_o     (icpsel),
    .lpfres_o     (lpfres),
    .lpfcap_o     (lpfcap),
    .sys_rst_o    (sys_rst),
    .locked_o     (locked),
    .error_o      (error),
    .lost_cnt_o   (lost_cnt),
    .cfg_valid_i  (cfg_valid),
    .cfg_icpsel_i (cfg_icpsel),
    .cfg_lpfres_i (cfg_lpfres),
    .cfg_lpfcap_i (cfg_lpfcap),
    .cfg_ready_o  (cfg_ready)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and check the always-true properties.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("no_enclk_in_reset", {31'd0, (enclk0 | enclk2) & pll_reset}, 32'd0);
    chk("enclk2_implies_enclk0", {31'd0, enclk2 & ~enclk0}, 32'd0);
    chk("loop_settings", {21'd0, icpsel, lpfres, lpfcap}, {21'd0, exp_loop});
    chk("lost_cnt", {24'd0, lost_cnt}, {24'd0, exp_lost});
  endtask

  // Current sample is the first high cycle of a reset pulse; expect RC high cycles then a fall.
  task automatic reset_pulse(input string tag);
    chk({tag, "_hi"}, {31'd0, pll_reset}, 32'd1);
    for (int i = 1; i < RC; i++) begin
      tick();
      chk({tag, "_hi"}, {31'd0, pll_reset}, 32'd1);
    end
    tick();
    chk({tag, "_fall"}, {31'd0, pll_reset}, 32'd0);
  endtask

  // Raise lock and follow the bring-up by elapsed-cycle formula until RUN.
  task automatic run_up(input string tag);
    lock = 1'b1;
    for (int k = 1; k <= T_RUN; k++) begin
      tick();
      chk({tag, "_enclk0"}, {31'd0, enclk0}, {31'd0, k >= T_E0});
      chk({tag, "_enclk2"}, {31'd0, enclk2}, {31'd0, k >= T_E2});
      chk({tag, "_sys_rst"}, {31'd0, sys_rst}, {31'd0, k < T_RUN});
      chk({tag, "_locked"}, {31'd0, locked}, {31'd0, k >= T_RUN});
      chk({tag, "_cfg_ready"}, {31'd0, cfg_ready}, {31'd0, k >= T_RUN});
      chk({tag, "_pll_reset"}, {31'd0, pll_reset}, 32'd0);
    end
  endtask

  // Drop lock in RUN: outputs hold for two sync cycles, then everything shuts off.
  task automatic lose_lock(input string tag);
    lock = 1'b0;
    tick();
    tick();
    chk({tag, "_still_enabled"}, {31'd0, enclk0 & ~sys_rst}, 32'd1);
    exp_lost = (exp_lost == 8'hFF) ? exp_lost : exp_lost + 8'd1;
    tick();
    chk({tag, "_off"}, {28'd0, enclk0, enclk2, sys_rst, locked}, {28'd0, 4'b0010});
    reset_pulse({tag, "_pulse"});
  endtask

  // Config handshake, optionally landing on the same edge as a lock loss.
  task automatic reconfig(input string tag, input logic [5:0] icp, input logic [2:0] res,
                          input logic [1:0] cap, input bit with_loss);
    if (with_loss) begin
      lock = 1'b0;
      tick();
      tick();
      exp_lost = (exp_lost == 8'hFF) ? exp_lost : exp_lost + 8'd1;
    end
    cfg_valid  = 1'b1;
    cfg_icpsel = icp;
    cfg_lpfres = res;
    cfg_lpfcap = cap;
    exp_loop   = {icp, res, cap};
    tick();
    cfg_valid = 1'b0;
    lock      = 1'b0;
    chk({tag, "_pll_reset"}, {31'd0, pll_reset}, 32'd1);
    chk({tag, "_error_clr"}, {31'd0, error}, 32'd0);
    chk({tag, "_ready_drop"}, {31'd0, cfg_ready}, 32'd0);
    chk({tag, "_outs_off"}, {29'd0, enclk0, sys_rst, locked}, {29'd0, 3'b010});
    reset_pulse({tag, "_pulse"});
  endtask

  // Hold lock low through one WAIT_LOCK window and check the timeout reaction.
  task automatic timeout_step(input string tag, input bit expect_error);
    for (int i = 1; i < LT; i++) begin
      tick();
      chk({tag, "_waiting"}, {31'd0, pll_reset}, 32'd0);
    end
    tick();
    chk({tag, "_reset_rise"}, {31'd0, pll_reset}, 32'd1);
    chk({tag, "_error"}, {31'd0, error}, {31'd0, expect_error});
    chk({tag, "_cfg_ready"}, {31'd0, cfg_ready}, {31'd0, expect_error});
  endtask

  initial begin
    logic [5:0] r_icp;
    logic [2:0] r_res;
    logic [1:0] r_cap;
    int choice;

    rst        = 1'b1;
    lock       = 1'b0;
    cfg_valid  = 1'b0;
    cfg_icpsel = 6'd0;
    cfg_lpfres = 3'd0;
    cfg_lpfcap = 2'd0;
    exp_loop   = {6'd16, 3'd2, 2'd0};
    exp_lost   = 8'd0;

    // Reset state
    repeat (3) tick();
    chk("rst_values", {25'd0, pll_reset, enclk0, enclk2, sys_rst, locked, error, cfg_ready},
        {25'd0, 7'b1001000});

    // Clean bring-up
    rst = 1'b0;
    reset_pulse("bringup_pulse");
    repeat (5) tick();
    run_up("bringup");
    repeat (3) begin
      tick();
      chk("run_hold", {30'd0, locked, sys_rst}, {30'd0, 2'b10});
    end

    // Lock loss in RUN
    lose_lock("run_loss");

    // Lock glitch four cycles into STABLE: qualification restarts from the re-rise
    tick();
    tick();
    lock = 1'b1;
    repeat (7) begin
      tick();
      chk("glitch_pre_enclk0", {31'd0, enclk0}, 32'd0);
    end
    lock = 1'b0;
    tick();
    run_up("after_glitch");

    // Two timeouts after a lock loss lead to ERROR
    lose_lock("run_loss2");
    timeout_step("timeout1", 1'b0);
    reset_pulse("timeout1_pulse");
    timeout_step("timeout2", 1'b1);
    repeat (6) begin
      tick();
      chk("error_hold", {28'd0, pll_reset, error, enclk0, sys_rst}, {28'd0, 4'b1101});
    end

    // Reconfig from ERROR, then full re-sequence with the new values
    reconfig("cfg_err", 6'd40, 3'd5, 2'd3, 1'b0);
    repeat (3) tick();
    run_up("cfg_err_up");

    // Reconfig from RUN with a different setting
    r_icp = 6'($urandom_range(0, 63));
    if (r_icp == 6'd40) r_icp = 6'd41;
    reconfig("cfg_run", r_icp, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b0);
    tick();
    run_up("cfg_run_up");

    // Accept and lock loss on the same edge
    reconfig("cfg_loss", 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 1'b1);
    tick();

    // rst_i asserted in EN_CLK restores everything including the default loop settings
    lock = 1'b1;
    repeat (T_E0 + 1) tick();
    chk("enclk_phase", {30'd0, enclk0, enclk2}, {30'd0, 2'b10});
    rst      = 1'b1;
    exp_loop = {6'd16, 3'd2, 2'd0};
    exp_lost = 8'd0;
    tick();
    chk("mid_rst_values", {25'd0, pll_reset, enclk0, enclk2, sys_rst, locked, error, cfg_ready},
        {25'd0, 7'b1001000});
    lock = 1'b0;
    tick();
    rst = 1'b0;
    reset_pulse("post_rst_pulse");

    // Randomized sessions: random lock delay, dwell and exit path
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 15)) tick();
      run_up("rand_up");
      repeat ($urandom_range(1, 8)) begin
        tick();
        chk("rand_run", {31'd0, locked}, 32'd1);
      end
      choice = $urandom_range(0, 2);
      r_icp  = 6'($urandom_range(0, 63));
      r_res  = 3'($urandom_range(0, 7));
      r_cap  = 2'($urandom_range(0, 3));
      if (choice == 0) begin
        lose_lock("rand_loss");
      end else begin
        reconfig("rand_cfg", r_icp, r_res, r_cap, choice == 2);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gowin_pll_ctrl.md
# gowin_pll_ctrl

Power-up and recovery sequencer for the Gowin PLL wrapper on the GW5AST board. It runs on the 50 MHz board reference clock and holds the PLL in reset for a fixed time. It waits for a stable lock, then enables the two output clocks in order and releases the system reset. It drives the dynamic charge-pump and loop-filter settings, restarts the PLL on lock loss, and reports an error after repeated lock timeouts.

## Interface
Parameters:
- RESET_CYCLES, 16: PLL reset pulse length, in clk_i cycles.
- LOCK_TIMEOUT, 50000: maximum cycles to wait for lock after reset release.
- STABLE_CYCLES, 1024: consecutive locked cycles required before clocks are enabled.
- EN_GAP_CYCLES, 8: gap between enclk0 rise, enclk2 rise and sys_rst fall.
- MAX_RETRIES, 3: consecutive lock timeouts before entering ERROR.
- DEFAULT_ICPSEL, 6'd16 / DEFAULT_LPFRES, 3'd2 / DEFAULT_LPFCAP, 2'd0: loop settings applied after rst_i.

Ports:
- clk_i  in  1  50 MHz reference clock (same net as the PLL clkin).
- rst_i  in  1  reset; synchronous, active-high.
- lock_i  in  1  PLL lock; asynchronous to clk_i.
- pll_reset_o  out  1  PLL reset.
- enclk0_o, enclk2_o  out  1 each  PLL output clock enables.
- icpsel_o  out  6  charge-pump select.
- lpfres_o  out  3  loop-filter resistor select.
- lpfcap_o  out  2  loop-filter capacitor select.
- sys_rst_o  out  1  active-high reset for logic clocked by the PLL outputs.
- locked_o  out  1  high in RUN only.
- error_o  out  1  high in ERROR.
- lost_cnt_o  out  8  count of lock-loss events; saturates at 255.
- cfg_valid_i  in  1  request to apply new loop settings.
- cfg_icpsel_i  in  6  requested charge-pump select.
- cfg_lpfres_i  in  3  requested loop-filter resistor select.
- cfg_lpfcap_i  in  2  requested loop-filter capacitor select.
- cfg_ready_o  out  1  high in RUN and ERROR; a config is accepted on cfg_valid_i && cfg_ready_o.

## Operation
- lock_i passes through a 2-flop synchronizer to give lock_s. All FSM decisions use lock_s.
- All outputs are registered.
- Reset values: state RESET_PLL, counter 0, retries 0, pll_reset_o=1, enclk0_o=enclk2_o=0, sys_rst_o=1, locked_o=0, error_o=0, cfg_ready_o=0, lost_cnt_o=0, loop outputs at their DEFAULT_* values.
- RESET_PLL: pll_reset_o=1 for exactly RESET_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK: pll_reset_o=0 and the timeout counter runs.
  - lock_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT: retries++. Go to ERROR if retries reaches MAX_RETRIES, otherwise go to RESET_PLL.
- STABLE: counts consecutive lock_s=1 cycles.
  - lock_s=0: go to WAIT_LOCK, timeout counter restarted, retries unchanged.
  - STABLE_CYCLES reached: go to EN_CLK.
- EN_CLK: enclk0_o=1 on entry. enclk2_o=1 EN_GAP_CYCLES later. sys_rst_o=0 a further EN_GAP_CYCLES later, together with entry to RUN. retries is cleared on entering RUN.
- RUN: locked_o=1 and cfg_ready_o=1.
- Lock loss: lock_s=0 in EN_CLK or RUN causes the following, registered in one step:
  - enclk0_o=enclk2_o=0, sys_rst_o=1, locked_o=0.
  - lost_cnt_o increments, saturating at 255.
  - Next state RESET_PLL.
- ERROR: pll_reset_o=1 held, error_o=1, enables 0, sys_rst_o=1. The FSM leaves ERROR only on rst_i or a config handshake.
- Config handshake: the cfg_* values are latched into the loop outputs, retries and error_o are cleared, and the FSM goes to RESET_PLL. Loop outputs change only here or on rst_i, and therefore only while pll_reset_o is, or becomes, 1.
- Config accept and lock loss in the same cycle: the config is latched, lost_cnt_o increments, and the FSM goes to RESET_PLL.
- rst_i mid-sequence: reset values apply on the next edge from any state. Latched cfg values are discarded and DEFAULT_* values are restored.
- Counter width: $clog2 of the largest of the count parameters, plus 1. Counters never wrap.

## Timing
- lock_i rising at edge t gives lock_s=1 at t+2 and STABLE at t+3.
- Lock-up to sys_rst_o fall = 2 (sync) + 1 + STABLE_CYCLES + 2·EN_GAP_CYCLES cycles, with lock_i held high throughout.
- lock_i falling in RUN at t: outputs are disabled at t+3 (2 sync + 1 registered).
- Timeout path: RESET_CYCLES + LOCK_TIMEOUT cycles per attempt.
- pll_reset_o is never low for less than one full WAIT_LOCK cycle.
- enclk0_o/enclk2_o are never high while pll_reset_o=1.
- cfg_ready_o drops in the cycle after an accept.

## Structure
- Package gowin_pll_ctrl_pkg holds:
  - the state enum (RESET_PLL, WAIT_LOCK, STABLE, EN_CLK, RUN, ERROR);
  - the loop-setting typedefs icpsel_t [5:0], lpfres_t [2:0], lpfcap_t [1:0];
  - the DEFAULT_* constants.
- Sub-module gowin_pll_lock_sync: 2-flop synchronizer with reset value 0.
- Top-level integration connects the ports one-to-one to the PLL wrapper's reset, lock, enclk0, enclk2, icpsel, lpfres and lpfcap.

## Test plan
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, EN_GAP_CYCLES=2, MAX_RETRIES=2.
- Clean bring-up: release rst_i, raise lock_i 5 cycles after pll_reset_o falls. Expect:
  - pll_reset_o high for exactly 4 cycles;
  - enclk0_o rises 11 cycles after lock_i;
  - enclk2_o rises 2 cycles later;
  - sys_rst_o falls and locked_o rises 2 cycles after that.
- Lock glitch in STABLE: drop lock_i for 1 cycle 4 cycles after entering STABLE. Expect the stable count to restart, no enables, and retries still 0.
- Timeouts: hold lock_i=0. Expect two 4-cycle reset pulses 24 cycles apart, then error_o=1 with pll_reset_o held high.
- Lock loss in RUN: drop lock_i. Expect enclk0_o=enclk2_o=0 and sys_rst_o=1 3 cycles later, lost_cnt_o=1, and a fresh 4-cycle reset pulse.
- Reconfig from RUN and from ERROR: apply cfg 6'd40/3'd5/2'd3 with cfg_valid_i. Expect:
  - the outputs update on the edge where pll_reset_o rises;
  - error_o clears;
  - full re-sequence with the new values held.
- rst_i asserted in EN_CLK: expect all reset values on the next edge and loop outputs back at 16/2/0.
